// File: rtl/seg_scan_if.sv
// Handshake/bus bundle between a segment-word producer and the seg_scan display driver.
// The master drives enable/load/digits; the slave drives the display and status pulses.
interface seg_scan_if;
    logic        en;
    logic        load;
    logic [31:0] digits;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        loaded;
    logic        frame_done;

    modport master (
        output en, load, digits,
        input  an, seg, loaded, frame_done
    );

    modport slave (
        input  en, load, digits,
        output an, seg, loaded, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with per-slot dead time and frame-aligned word swap.
// Optional leading-zero blanking is enabled by defining ZERO_BLANK_EN.
//
//  state | meaning
//  GAP   | dead time at start of a digit slot, all anodes and segments off
//  SHOW  | anode idx driven, segments show active byte idx
module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter bit AN_ACT_LOW   = 1'b1,
    parameter bit SEG_ACT_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
    localparam logic [3:0]    AN_OFF   = AN_ACT_LOW  ? 4'hF  : 4'h0;
    localparam logic [7:0]    SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;

    typedef enum logic {GAP, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [31:0]   active;
    logic [31:0]   pending;
    logic          pend_vld;

    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx_nxt;
    logic          wrap;
    logic          boundary;
    logic [7:0]    cur_byte;
    logic          blank_dig;
    logic [3:0]    an_sel;

    always_comb begin
        wrap     = (cnt == CNT_LAST);
        boundary = bus.en && (idx == 2'd0) && (cnt == '0);
        cnt_nxt  = '0;
        idx_nxt  = 2'd0;
        if (bus.en) begin
            if (wrap) begin
                cnt_nxt = '0;
                idx_nxt = idx + 2'd1;
            end else begin
                cnt_nxt = cnt + 1'b1;
                idx_nxt = idx;
            end
        end
    end

    always_comb begin
        cur_byte = active[{idx, 3'b000} +: 8];
        an_sel   = 4'b0001 << idx;
`ifdef ZERO_BLANK_EN
        // a digit is blanked only while every digit to its left is also "0"
        case (idx)
            2'd0:    blank_dig = (active[7:0] == 8'h3F);
            2'd1:    blank_dig = (active[15:0] == 16'h3F3F);
            2'd2:    blank_dig = (active[23:0] == 24'h3F3F3F);
            default: blank_dig = 1'b0;
        endcase
`else
        blank_dig = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= GAP;
            cnt            <= '0;
            idx            <= 2'd0;
            active         <= 32'h0;
            pending        <= 32'h0;
            pend_vld       <= 1'b0;
            bus.an         <= AN_OFF;
            bus.seg        <= SEG_OFF;
            bus.loaded     <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= (cnt_nxt >= BLANK_C) ? SHOW : GAP;

            // a load coinciding with the swap keeps pend_vld set for the next frame
            if (bus.load) begin
                pending  <= bus.digits;
                pend_vld <= 1'b1;
            end
            if (boundary && pend_vld) begin
                active <= pending;
                if (!bus.load) pend_vld <= 1'b0;
            end

            bus.loaded     <= boundary && pend_vld;
            bus.frame_done <= bus.en && (idx == 2'd3) && wrap;

            if (bus.en && state == SHOW) begin
                bus.an  <= AN_ACT_LOW ? ~an_sel : an_sel;
                if (blank_dig)
                    bus.seg <= SEG_OFF;
                else
                    bus.seg <= SEG_ACT_LOW ? ~cur_byte : cur_byte;
            end else begin
                bus.an  <= AN_OFF;
                bus.seg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at SCAN_DIV=8, BLANK_CYCLES=2, an active-low, seg active-high.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    seg_scan_if bus();

    seg_scan #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .AN_ACT_LOW  (1'b1),
        .SEG_ACT_LOW (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [31:0] w, input int slot);
        logic [7:0] b;
        b = w[8*slot +: 8];
`ifdef ZERO_BLANK_EN
        if (slot < 3) begin
            logic blank;
            blank = 1'b1;
            for (int k = 0; k <= slot; k++)
                if (w[8*k +: 8] != 8'h3F) blank = 1'b0;
            if (blank) b = 8'h00;
        end
`endif
        return b;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [31:0] w);
        bus.digits = w;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic wait_frame();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.frame_done) found = 1'b1;
        end
        check("frame_wait", {31'b0, found}, 32'd1);
    endtask

    // Starts on the boundary cycle; j counts falling edges after it (1..32).
    task automatic scan_frame(input logic [31:0] w, input logic exp_loaded, input logic chk_an,
                              input logic do_ld, input logic [31:0] ld_word);
        int slot, pos;
        logic [3:0] an_exp;
        logic [7:0] seg_exp;
        if (do_ld) begin
            bus.digits = ld_word;
            bus.load   = 1'b1;
        end
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            if (j == 1) bus.load = 1'b0;
            slot = (j - 1) / 8;
            pos  = (j - 1) % 8;
            if (pos < 2) begin
                an_exp  = 4'hF;
                seg_exp = 8'h00;
            end else begin
                an_exp  = ~(4'b0001 << slot);
                seg_exp = exp_seg(w, slot);
            end
            check($sformatf("seg j=%0d", j), {24'b0, bus.seg}, {24'b0, seg_exp});
            if (chk_an) check($sformatf("an j=%0d", j), {28'b0, bus.an}, {28'b0, an_exp});
            check($sformatf("loaded j=%0d", j), {31'b0, bus.loaded},
                  {31'b0, (j == 1) ? exp_loaded : 1'b0});
            check($sformatf("frame_done j=%0d", j), {31'b0, bus.frame_done},
                  {31'b0, (j == 32)});
        end
    endtask

    initial begin
        bus.en     = 1'b1;
        bus.load   = 1'b0;
        bus.digits = 32'h0;

        // reset values
        step(2);
        check("rst an", {28'b0, bus.an}, 32'hF);
        check("rst seg", {24'b0, bus.seg}, 32'h0);
        check("rst loaded", {31'b0, bus.loaded}, 32'h0);
        check("rst frame_done", {31'b0, bus.frame_done}, 32'h0);
        rst = 1'b0;

        // idle scan: blank segments, frame_done every 32 cycles, no loaded
        wait_frame();
        scan_frame(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // single load mid-frame shows from the next frame
        step(3);
        pulse_load(32'h6F7D0607);
        wait_frame();
        scan_frame(32'h6F7D0607, 1'b1, 1'b1, 1'b0, 32'h0);

        // two loads in one frame: last wins, one loaded pulse
        step(2);
        pulse_load(32'h3F3F3F3F);
        step(5);
        pulse_load(32'h06060606);
        wait_frame();
        scan_frame(32'h06060606, 1'b1, 1'b1, 1'b0, 32'h0);
        scan_frame(32'h06060606, 1'b0, 1'b1, 1'b0, 32'h0);

        // load on the boundary while a word is pending
        step(5);
        pulse_load(32'h4F5B0666);
        wait_frame();
        scan_frame(32'h4F5B0666, 1'b1, 1'b1, 1'b1, 32'h7F6D664F);
        scan_frame(32'h7F6D664F, 1'b1, 1'b1, 1'b0, 32'h0);

        // drop en mid-slot of digit 2, load while disabled, then restart
        step(20);
        check("pre-drop an", {28'b0, bus.an}, 32'hB);
        check("pre-drop seg", {24'b0, bus.seg}, 32'h6D);
        bus.en = 1'b0;
        @(negedge clk);
        check("drop an", {28'b0, bus.an}, 32'hF);
        check("drop seg", {24'b0, bus.seg}, 32'h0);
        pulse_load(32'h5B3F3F3F);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("off an", {28'b0, bus.an}, 32'hF);
            check("off loaded", {31'b0, bus.loaded}, 32'h0);
            check("off frame_done", {31'b0, bus.frame_done}, 32'h0);
        end
        bus.en = 1'b1;
        scan_frame(32'h5B3F3F3F, 1'b1, 1'b1, 1'b0, 32'h0);

        // all-zero word
        step(3);
        pulse_load(32'h3F3F3F3F);
        wait_frame();
        scan_frame(32'h3F3F3F3F, 1'b1, 1'b1, 1'b0, 32'h0);

        // reset mid-frame discards the pending word
        step(5);
        pulse_load(32'h77777777);
        step(2);
        rst = 1'b1;
        #1;
        check("mid rst an", {28'b0, bus.an}, 32'hF);
        check("mid rst seg", {24'b0, bus.seg}, 32'h0);
        check("mid rst loaded", {31'b0, bus.loaded}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_frame();
        scan_frame(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
